mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Target end of the byte-serial memory bus driven by the CPU memory controller.
- Services one byte per cycle: RAM reads with fixed 1-cycle latency, RAM writes, and memory-mapped I/O writes into a TX byte FIFO.
- Generates the I/O-buffer-full back-pressure flag that the controller stalls on.
- Sits between the core's memory controller and the on-chip RAM / UART-style output path.

Parameters:
- RAM_AW, 17: RAM byte-address width; RAM is 2^RAM_AW bytes.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, >= 4.
- FULL_MARGIN, 2: free entries remaining when oIO_buffer_full asserts.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- rdy  in  1  global enable; bus-side actions only when high.
- iMEM_rw  in  1  1=write, 0=read.
- iMEM_addr  in  32  byte address.
- iMEM_dt  in  8  write data.
- oMEM_dt  out  8  read data, registered.
- oIO_buffer_full  out  1  back-pressure to memory controller, registered.
- oTX_valid  out  1  TX FIFO head valid.
- oTX_dt  out  8  TX FIFO head byte.
- iTX_ready  in  1  downstream accepts head.
- oOverflow  out  1  sticky: an I/O write was dropped.
- oHalt  out  1  simulation halt request (see Optional Feature).

Behaviour:
- Decode: I/O space when iMEM_addr[17:16]==2'b11. Otherwise RAM, index iMEM_addr[RAM_AW-1:0]; upper bits are ignored (aliasing).
- I/O registers:
  - 0x30000 = TX data.
  - 0x30004 = status/halt.
  - Any other I/O offset: writes ignored, reads return 0x00.
- RAM read: when rdy & !rw & RAM space, oMEM_dt <= mem[addr] at the next posedge (latency 1).
- RAM write: when rdy & rw & RAM space, mem[addr] <= iMEM_dt at posedge. oMEM_dt holds its previous value.
- Read-during-write to the same address is impossible (a single rw line).
- I/O reads, 1-cycle latency:
  - 0x30000 returns 0x00.
  - 0x30004 returns {oOverflow, 3'b0, count[3:0]}, count saturating at 15.
- rdy low: no RAM write, no FIFO push, oMEM_dt holds. TX-side pop still proceeds (the downstream side is independent of rdy).
- TX FIFO:
  - Circular buffer, pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
  - push = rdy & rw & addr==0x30000.
  - pop = oTX_valid & iTX_ready.
  - oTX_valid = (count!=0); oTX_dt = head entry. Both combinational from registered state.
  - Push and pop in the same cycle: both occur, count unchanged; allowed even when full.
  - Push when count==FIFO_DEPTH with no pop: byte dropped, oOverflow <= 1 (sticky until reset).
  - Pop when empty cannot occur (gated by valid).
- oIO_buffer_full <= (next_count >= FIFO_DEPTH-FULL_MARGIN); registered, so the controller sees it one cycle after the crossing push. The margin absorbs the in-flight write.
- Reset (asynchronous, rst_n low), effective immediately, including mid-transfer:
  - Outputs: oMEM_dt=0, oTX_valid=0, oIO_buffer_full=0, oOverflow=0, oHalt=0.
  - Internal: pointers=0, count=0.
  - RAM contents are not reset.
  - A partially pushed or unpopped FIFO is discarded.

Optional Feature:
- Macro SIM_HALT_EN.
- Defined:
  - A write to 0x30004 sets an internal halt_req.
  - oHalt <= 1 on the first posedge where halt_req=1 and count==0, i.e. after all prior TX bytes have drained. Sticky until reset.
  - Further pushes after halt_req are still accepted and delay oHalt until drained.
- Undefined: writes to 0x30004 are ignored; oHalt is constant 0.

Test Plan:
- RAM round trip: write 0xA5 to 0x00010, then read 0x00010 the next cycle -> oMEM_dt==0xA5 one cycle after the read. Read of 0x20010 (aliasing with RAM_AW=17) -> 0xA5.
- Read latency with rdy: read 0x00010 with rdy=0 for 3 cycles, then rdy=1 -> oMEM_dt unchanged until 1 cycle after the first rdy=1 read.
- FIFO fill with iTX_ready=0, writing 0x41..0x48 to 0x30000:
  - oIO_buffer_full rises the cycle after the 6th push.
  - 9th write -> oOverflow=1, count stays 8.
  - Status read -> 0x88.
- Drain: iTX_ready=1 -> oTX_dt sequence 0x41..0x48 in order, oTX_valid drops after 8 pops, oIO_buffer_full clears when count<6.
- Simultaneous push/pop at count==8 with iTX_ready=1 -> no overflow, count stays 8, new byte appears after 7 more pops.
- SIM_HALT_EN: push 0x58, write 0x30004, then drain -> oHalt=1 exactly the cycle after the FIFO empties. Assert rst_n=0 mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Byte-serial memory bus target: RAM with 1-cycle reads, TX byte FIFO with back-pressure.
// Optional SIM_HALT_EN: a write to the status register requests a halt once the TX FIFO drains.
module mem_bus_responder #(
    parameter int RAM_AW      = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        iMEM_rw,
    input  logic [31:0] iMEM_addr,
    input  logic [7:0]  iMEM_dt,
    output logic [7:0]  oMEM_dt,
    output logic        oIO_buffer_full,
    output logic        oTX_valid,
    output logic [7:0]  oTX_dt,
    input  logic        iTX_ready,
    output logic        oOverflow,
    output logic        oHalt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] ADDR_TX   = 32'h0003_0000;
    localparam logic [31:0] ADDR_STAT = 32'h0003_0004;

    logic [7:0]        mem  [0:(1<<RAM_AW)-1];
    logic [7:0]        fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_io;
    logic              tx_sel;
    logic              stat_sel;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              drop;
    logic [3:0]        cnt_sat;
    logic [7:0]        io_rd_dt;

    assign ram_idx  = iMEM_addr[RAM_AW-1:0];
    assign is_io    = (iMEM_addr[17:16] == 2'b11);
    assign tx_sel   = (iMEM_addr == ADDR_TX);
    assign stat_sel = (iMEM_addr == ADDR_STAT);

    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign push_req   = rdy && iMEM_rw && tx_sel;
    assign pop        = oTX_valid && iTX_ready;
    assign push_ok    = push_req && ((count != CW'(FIFO_DEPTH)) || pop);
    assign drop       = push_req && !push_ok;
    assign next_count = count + CW'(push_ok) - CW'(pop);

    assign oTX_valid = (count != '0);
    assign oTX_dt    = fifo[rd_ptr];

    always_comb begin
        cnt_sat = (32'(count) > 32'd15) ? 4'hF : 4'(count);
        io_rd_dt = 8'h00;
        if (stat_sel)
            io_rd_dt = {oOverflow, 3'b000, cnt_sat};
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (rdy && iMEM_rw && !is_io)
            mem[ram_idx] <= iMEM_dt;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo[wr_ptr] <= iMEM_dt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oMEM_dt <= 8'h00;
        else if (rdy && !iMEM_rw)
            oMEM_dt <= is_io ? io_rd_dt : mem[ram_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            oIO_buffer_full <= 1'b0;
            oOverflow       <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= next_count;
            // Margin leaves room for the write already in flight when the flag is seen.
            oIO_buffer_full <= (next_count >= CW'(FIFO_DEPTH - FULL_MARGIN));
            if (drop)
                oOverflow <= 1'b1;
        end
    end

`ifdef SIM_HALT_EN
    logic halt_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_req <= 1'b0;
            oHalt    <= 1'b0;
        end else begin
            if (rdy && iMEM_rw && stat_sel)
                halt_req <= 1'b1;
            if (halt_req && (count == '0))
                oHalt <= 1'b1;
        end
    end
`else
    assign oHalt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios plus random traffic against a queue model.
module tb_mem_bus_responder;

    localparam int D = 8;
    localparam int M = 2;
`ifdef SIM_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdt;
    logic [7:0]  mem_rdt;
    logic        io_full;
    logic        tx_valid;
    logic [7:0]  tx_dt;
    logic        tx_ready;
    logic        overflow;
    logic        halt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram_m [bit [31:0]];
    logic [7:0] q [$];
    logic [7:0] exp_dt;
    bit         ovf_m, full_m, halt_m, halt_req_m;

    always #5 clk = ~clk;

    mem_bus_responder #(.RAM_AW(17), .FIFO_DEPTH(D), .FULL_MARGIN(M)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .iMEM_rw         (mem_rw),
        .iMEM_addr       (mem_addr),
        .iMEM_dt         (mem_wdt),
        .oMEM_dt         (mem_rdt),
        .oIO_buffer_full (io_full),
        .oTX_valid       (tx_valid),
        .oTX_dt          (tx_dt),
        .iTX_ready       (tx_ready),
        .oOverflow       (overflow),
        .oHalt           (halt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dt     = 8'h00;
        ovf_m      = 1'b0;
        full_m     = 1'b0;
        halt_m     = 1'b0;
        halt_req_m = 1'b0;
    endtask

    // One bus cycle seen from the specification's point of view, evaluated on pre-edge state.
    task automatic model_tick();
        int  sz;
        bit  pop_m;
        bit  ram_sp;
        sz     = q.size();
        pop_m  = (sz != 0) && tx_ready;
        ram_sp = (mem_addr[17:16] != 2'b11);
        if (rdy && !mem_rw) begin
            if (!ram_sp)
                exp_dt = (mem_addr == 32'h0003_0004) ?
                         {ovf_m, 3'b000, (sz > 15) ? 4'hF : 4'(sz)} : 8'h00;
            else if (ram_m.exists({15'd0, mem_addr[16:0]}))
                exp_dt = ram_m[{15'd0, mem_addr[16:0]}];
            else
                exp_dt = 8'hxx;
        end
        if (HALT_EN && halt_req_m && sz == 0)
            halt_m = 1'b1;
        if (rdy && mem_rw && ram_sp)
            ram_m[{15'd0, mem_addr[16:0]}] = mem_wdt;
        if (HALT_EN && rdy && mem_rw && mem_addr == 32'h0003_0004)
            halt_req_m = 1'b1;
        if (pop_m)
            void'(q.pop_front());
        if (rdy && mem_rw && mem_addr == 32'h0003_0000) begin
            if (sz < D || pop_m)
                q.push_back(mem_wdt);
            else
                ovf_m = 1'b1;
        end
        full_m = (q.size() >= D - M);
    endtask

    task automatic compare_all();
        check_val("mem_dt", mem_rdt, exp_dt);
        check_val("tx_valid", tx_valid, q.size() != 0);
        if (q.size() != 0)
            check_val("tx_dt", tx_dt, q[0]);
        check_val("io_full", io_full, full_m);
        check_val("overflow", overflow, ovf_m);
        check_val("halt", halt, halt_m);
    endtask

    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [7:0] d, input logic t);
        rdy      = r;
        mem_rw   = w;
        mem_addr = a;
        mem_wdt  = d;
        tx_ready = t;
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_mem_dt", mem_rdt, 8'h00);
        check_val("rst_tx_valid", tx_valid, 1'b0);
        check_val("rst_io_full", io_full, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_halt", halt, 1'b0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rdy      = 1'b0;
        mem_rw   = 1'b0;
        mem_addr = 32'h0;
        mem_wdt  = 8'h0;
        tx_ready = 1'b0;
        model_reset();
        #12;
        check_val("rst_mem_dt", mem_rdt, 8'h00);
        check_val("rst_tx_valid", tx_valid, 1'b0);
        check_val("rst_io_full", io_full, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_halt", halt, 1'b0);
        rst_n = 1'b1;

        // RAM round trip and aliasing
        cyc(1, 1, 32'h0001_0010, 8'hA5, 0);
        cyc(1, 0, 32'h0001_0010, 8'h00, 0);
        check_val("ram_rd", mem_rdt, 8'hA5);
        cyc(1, 1, 32'h0000_0010, 8'hA5, 0);
        cyc(1, 0, 32'h0000_0010, 8'h00, 0);
        check_val("ram_rd_low", mem_rdt, 8'hA5);
        cyc(1, 0, 32'h0002_0010, 8'h00, 0);
        check_val("ram_alias", mem_rdt, 8'hA5);

        // rdy low holds read data
        cyc(1, 1, 32'h0000_0011, 8'h5A, 0);
        cyc(1, 0, 32'h0000_0011, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h0000_0010, 8'h00, 0);
            check_val("rdy_hold", mem_rdt, 8'h5A);
        end
        cyc(1, 0, 32'h0000_0010, 8'h00, 0);
        check_val("rdy_read", mem_rdt, 8'hA5);

        // FIFO fill, full flag and overflow
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 32'h0003_0000, 8'(8'h41 + i), 0);
            check_val("fill_full", io_full, (i + 1) >= 6);
        end
        cyc(1, 1, 32'h0003_0000, 8'h49, 0);
        check_val("ovf_set", overflow, 1'b1);
        cyc(1, 0, 32'h0003_0004, 8'h00, 0);
        check_val("status", mem_rdt, 8'h88);

        // Drain in order
        for (int k = 0; k < 8; k++) begin
            check_val("drain_dt", tx_dt, 8'(8'h41 + k));
            cyc(1, 0, 32'h0003_0008, 8'h00, 1);
            check_val("drain_full", io_full, (8 - k - 1) >= 6);
        end
        check_val("drain_empty", tx_valid, 1'b0);

        // Push and pop together at full
        async_reset();
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 32'h0003_0000, 8'(8'h41 + i), 0);
        cyc(1, 1, 32'h0003_0000, 8'h50, 1);
        check_val("pp_ovf", overflow, 1'b0);
        cyc(1, 0, 32'h0003_0004, 8'h00, 0);
        check_val("pp_status", mem_rdt, 8'h08);
        for (int k = 0; k < 7; k++)
            cyc(1, 0, 32'h0003_0008, 8'h00, 1);
        check_val("pp_head", tx_dt, 8'h50);
        cyc(1, 0, 32'h0003_0008, 8'h00, 1);

        // Halt request waits for drain
        async_reset();
        cyc(1, 1, 32'h0003_0000, 8'h58, 0);
        cyc(1, 1, 32'h0003_0004, 8'h01, 0);
        cyc(1, 0, 32'h0003_0008, 8'h00, 1);
        check_val("halt_early", halt, 1'b0);
        cyc(1, 0, 32'h0003_0008, 8'h00, 1);
        check_val("halt_set", halt, HALT_EN);

        // Reset in the middle of a drain
        async_reset();
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 32'h0003_0000, 8'(8'h60 + i), 0);
        cyc(1, 0, 32'h0003_0008, 8'h00, 1);
        async_reset();
        cyc(1, 0, 32'h0003_0008, 8'h00, 1);

        // Preload the RAM window used by random traffic
        for (int i = 0; i < 64; i++)
            cyc(1, 1, 32'(i), 8'($urandom), 0);

        for (int n = 0; n < 1500; n++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel <= 5)
                a = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 1)) << 17)
                    | 32'($urandom_range(0, 63));
            else if (sel <= 7)
                a = 32'h0003_0000;
            else if (sel == 8)
                a = 32'h0003_0004;
            else
                a = ($urandom_range(0, 1) != 0) ? 32'h0003_0008 : 32'h0003_0001;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, a, 8'($urandom),
                $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
